axis_timing_generator: RTL and testbench



---
 rtl/axis_timing_generator.sv | 145 ++++++++++++++
 tb/tb_axis_timing_generator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/axis_timing_generator.sv
// rtl/axis_timing_generator.sv - step/direction timing engine: period ticks, step counter, pulse-width shaper
// Optional macro TIMING_DEBUG_EN adds debug_period_tick, debug_step_trigger, debug_step_tc outputs.
module axis_timing_generator #(
  parameter int WIDTH = 32
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             estop,
  input  logic             write,
  input  logic             instruction,
  input  logic             direction,
  input  logic [WIDTH-1:0] pulse_period,
  input  logic [WIDTH-1:0] pulse_count,
  input  logic [WIDTH-1:0] pulse_width,
  output logic             busy,
  output logic             error,
  output logic             pulse_out,
  output logic             direction_out
`ifdef TIMING_DEBUG_EN
  ,
  output logic             debug_period_tick,
  output logic             debug_step_trigger,
  output logic             debug_step_tc
`endif
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] period_cnt_q, period_cnt_d;
  logic [WIDTH-1:0] period_load_q, period_load_d;
  logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic [WIDTH-1:0] width_q, width_d;
  logic [WIDTH-1:0] shaper_cnt_q, shaper_cnt_d;
  logic             tick_q, tick_d;
  logic             trig_q, trig_d;
  logic             instr_q, instr_d;
  logic             dir_q, dir_d;
  logic             error_q, error_d;
  logic             pulse_q, pulse_d;
  logic             step_nz;

  assign step_nz = (step_cnt_q != ZERO);

  // Next-state logic for the period generator, step counter, shaper and command registers.
  always_comb begin
    period_cnt_d  = period_cnt_q;
    period_load_d = period_load_q;
    step_cnt_d    = step_cnt_q;
    width_d       = width_q;
    shaper_cnt_d  = shaper_cnt_q;
    tick_d        = 1'b0;
    trig_d        = 1'b0;
    instr_d       = instr_q;
    dir_d         = dir_q;
    error_d       = error_q;
    pulse_d       = 1'b0;

    if (estop) begin
      // Emergency stop wins over everything, including a concurrent write.
      period_cnt_d = ZERO;
      step_cnt_d   = ZERO;
      shaper_cnt_d = ZERO;
      error_d      = error_q | step_nz;
    end else begin
      // The shaper keeps running across a new command so an in-flight pulse completes.
      if (trig_q && (width_q != ZERO)) begin
        shaper_cnt_d = width_q;
      end else if (shaper_cnt_q != ZERO) begin
        shaper_cnt_d = shaper_cnt_q - ONE;
      end

      if (write) begin
        // Pending tick/trigger belong to the aborted command and are dropped.
        instr_d       = instruction;
        dir_d         = direction;
        period_load_d = (pulse_period == ZERO) ? ONE : pulse_period;
        period_cnt_d  = (pulse_period == ZERO) ? ONE : pulse_period;
        step_cnt_d    = pulse_count;
        width_d       = pulse_width;
        error_d       = 1'b0;
      end else if (enable) begin
        if (step_nz) begin
          if (period_cnt_q <= ONE) begin
            tick_d       = 1'b1;
            period_cnt_d = period_load_q;
          end else begin
            period_cnt_d = period_cnt_q - ONE;
          end
        end
        if (tick_q && step_nz) begin
          step_cnt_d = step_cnt_q - ONE;
          trig_d     = 1'b1;
        end
      end else begin
        // A tick that lands while disabled is held so no step is lost.
        tick_d = tick_q;
      end

      pulse_d = instr_q & (shaper_cnt_d != ZERO);
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      period_cnt_q  <= ZERO;
      period_load_q <= ZERO;
      step_cnt_q    <= ZERO;
      width_q       <= ZERO;
      shaper_cnt_q  <= ZERO;
      tick_q        <= 1'b0;
      trig_q        <= 1'b0;
      instr_q       <= 1'b0;
      dir_q         <= 1'b0;
      error_q       <= 1'b0;
      pulse_q       <= 1'b0;
    end else begin
      period_cnt_q  <= period_cnt_d;
      period_load_q <= period_load_d;
      step_cnt_q    <= step_cnt_d;
      width_q       <= width_d;
      shaper_cnt_q  <= shaper_cnt_d;
      tick_q        <= tick_d;
      trig_q        <= trig_d;
      instr_q       <= instr_d;
      dir_q         <= dir_d;
      error_q       <= error_d;
      pulse_q       <= pulse_d;
    end
  end

  assign busy          = step_nz;
  assign error         = error_q;
  assign pulse_out     = pulse_q;
  assign direction_out = dir_q;

`ifdef TIMING_DEBUG_EN
  assign debug_period_tick  = tick_q;
  assign debug_step_trigger = trig_q;
  assign debug_step_tc      = ~step_nz;
`endif

endmodule

// File: tb/tb_axis_timing_generator.sv
// tb/tb_axis_timing_generator.sv - scoreboard bench for axis_timing_generator
module tb_axis_timing_generator;

  logic        clock_in = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        estop = 1'b0;
  logic        write = 1'b0;
  logic        instruction = 1'b0;
  logic        direction = 1'b0;
  logic [31:0] pulse_period = '0;
  logic [31:0] pulse_count = '0;
  logic [31:0] pulse_width = '0;
  logic        busy, error, pulse_out, direction_out;

  axis_timing_generator #(.WIDTH(32)) dut (
    .clock_in      (clock_in),
    .reset         (reset),
    .enable        (enable),
    .estop         (estop),
    .write         (write),
    .instruction   (instruction),
    .direction     (direction),
    .pulse_period  (pulse_period),
    .pulse_count   (pulse_count),
    .pulse_width   (pulse_width),
    .busy          (busy),
    .error         (error),
    .pulse_out     (pulse_out),
    .direction_out (direction_out)
  );

  always #5 clock_in = ~clock_in;

  int cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  typedef struct {
    int   c;
    logic b;
    logic p;
    logic d;
    logic e;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
  endtask

  task automatic push_exp(input int c, input logic b, input logic p, input logic d, input logic e);
    exp_t x;
    x.c = c; x.b = b; x.p = p; x.d = d; x.e = e;
    sb.push_back(x);
  endtask

  // Compare every scoreboard entry due in the current cycle, mid-cycle.
  always @(negedge clock_in) begin
    while (sb.size() != 0 && sb[0].c <= cyc) begin
      exp_t x;
      x = sb.pop_front();
      check("busy", busy, x.b);
      check("pulse_out", pulse_out, x.p);
      check("direction_out", direction_out, x.d);
      check("error", error, x.e);
    end
  end

  task automatic issue_write(input logic ins, input logic dir, input int p, input int n,
                             input int w, output int t0);
    @(negedge clock_in);
    instruction = ins; direction = dir;
    pulse_period = p; pulse_count = n; pulse_width = w;
    write = 1'b1;
    @(posedge clock_in);
    #1;
    write = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clock_in);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clock_in);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    int t0;
    int k;
    repeat (3) @(posedge clock_in);
    #1 reset = 1'b0;
    @(negedge clock_in);
    check("rst busy", busy, 0);
    check("rst pulse", pulse_out, 0);
    check("rst error", error, 0);
    check("rst dir", direction_out, 0);
    enable = 1'b1;

    // P=4 N=4 W=1 PULSE: pulses after edges 6,10,14,18; busy falls after 17.
    issue_write(1'b1, 1'b1, 4, 4, 1, t0);
    for (int i = 0; i <= 22; i++)
      push_exp(t0 + i, (i < 17), (i == 6 || i == 10 || i == 14 || i == 18), 1'b1, 1'b0);
    drain(60);

    // DWELL P=4 N=16: no pulses, busy for P*N+1 samples.
    issue_write(1'b0, 1'b0, 4, 16, 4, t0);
    for (int i = 0; i <= 70; i++)
      push_exp(t0 + i, (i < 65), 1'b0, 1'b0, 1'b0);
    drain(120);

    // Width above period: continuous high from edge 4 through edge 12.
    issue_write(1'b1, 1'b0, 2, 3, 5, t0);
    for (int i = 0; i <= 16; i++)
      push_exp(t0 + i, (i < 7), (i >= 4 && i <= 12), 1'b0, 1'b0);
    drain(60);

    // Enable dropped for edges 8..17: later steps shift by exactly 10.
    issue_write(1'b1, 1'b1, 4, 3, 1, t0);
    for (int i = 0; i <= 28; i++)
      push_exp(t0 + i, (i < 23), (i == 6 || i == 20 || i == 24), 1'b1, 1'b0);
    wait_cyc(t0 + 7);
    enable = 1'b0;
    wait_cyc(t0 + 17);
    enable = 1'b1;
    drain(60);

    // Zero step count: never busy, never pulses.
    issue_write(1'b1, 1'b0, 2, 0, 2, t0);
    for (int i = 0; i <= 8; i++)
      push_exp(t0 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    drain(40);

    // Estop at edge 8 during a W=3 pulse; write under estop is ignored.
    issue_write(1'b1, 1'b0, 4, 10, 3, t0);
    for (int i = 0; i <= 14; i++)
      push_exp(t0 + i, (i < 8), (i == 6 || i == 7), 1'b0, (i >= 8));
    wait_cyc(t0 + 7);
    estop = 1'b1;
    wait_cyc(t0 + 8);
    instruction = 1'b1; direction = 1'b1;
    pulse_period = 2; pulse_count = 5; pulse_width = 1;
    write = 1'b1;
    wait_cyc(t0 + 9);
    write = 1'b0;
    wait_cyc(t0 + 10);
    estop = 1'b0;
    drain(40);

    // Next accepted write clears the sticky error.
    issue_write(1'b1, 1'b1, 4, 1, 1, t0);
    k = t0;
    for (int i = 0; i <= 8; i++)
      push_exp(k + i, (i < 5), (i == 6), 1'b1, 1'b0);
    drain(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
